// File: rtl/fp_stream_converter.sv
// Pipelined multi-lane floating-point format converter with valid/ready flow control,
// RNE/RTZ rounding, saturation, flush-to-zero and sticky exception flags.
module fp_stream_converter #(
  parameter int IN_EXP   = 8,
  parameter int IN_MANT  = 23,
  parameter int OUT_EXP  = 5,
  parameter int OUT_MANT = 10,
  parameter int LANES    = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [LANES*(1+IN_EXP+IN_MANT)-1:0]   in_data,
  input  logic                                  in_rmode,
  input  logic                                  in_sat,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [LANES*(1+OUT_EXP+OUT_MANT)-1:0] out_data,
  output logic [3:0]                            flags,
  input  logic                                  flag_clear
);

  localparam int IN_W  = 1 + IN_EXP + IN_MANT;
  localparam int OUT_W = 1 + OUT_EXP + OUT_MANT;
  localparam int EW    = ((IN_EXP > OUT_EXP) ? IN_EXP : OUT_EXP) + 2;
  localparam int BI    = (1 << (IN_EXP - 1)) - 1;
  localparam int BO    = (1 << (OUT_EXP - 1)) - 1;

  localparam logic [EW-1:0]       E_OFF     = EW'(BO - BI);
  localparam logic [EW-1:0]       E_OVF     = EW'((1 << OUT_EXP) - 1);
  localparam logic [EW-1:0]       E_ONE     = EW'(1);
  localparam logic [OUT_EXP-1:0]  EXP_ONES  = {OUT_EXP{1'b1}};
  localparam logic [OUT_EXP-1:0]  MAXF_EXP  = {{(OUT_EXP-1){1'b1}}, 1'b0};
  localparam logic [OUT_MANT-1:0] QNAN_MANT = OUT_MANT'(1) << (OUT_MANT - 1);

  logic s1_valid;
  logic s2_valid;
  logic s1_rmode;
  logic s1_sat;
  logic s1_adv;
  logic s2_adv;
  logic s1_load;
  logic s2_load;
  logic [3:0] beat_flags;

  logic [OUT_W-1:0] lane_res [LANES];
  logic [3:0]       lane_flg [LANES];

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_valid && s2_adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_rmode <= 1'b0;
      s1_sat   <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) s2_valid <= s1_valid;
      if (s1_load) begin
        s1_rmode <= in_rmode;
        s1_sat   <= in_sat;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic                in_sign;
    logic [IN_EXP-1:0]   in_exp;
    logic [IN_MANT-1:0]  in_mant;
    logic [OUT_MANT-1:0] kept;
    logic                guard;
    logic                sticky;
    logic                exp_ones;
    logic                exp_zero;
    logic                mant_nz;

    logic                s1_sign;
    logic                s1_nan;
    logic                s1_snan;
    logic                s1_inf;
    logic                s1_zero;
    logic                s1_znz;
    logic [EW-1:0]       s1_e;
    logic [OUT_MANT-1:0] s1_mant;
    logic                s1_guard;
    logic                s1_sticky;

    logic                round_up;
    logic [OUT_MANT:0]   sum;
    logic [EW-1:0]       e_rnd;
    logic [OUT_W-1:0]    res;
    logic [3:0]          lf;
    logic [OUT_W-1:0]    s2_res;
    logic [3:0]          s2_flg;

    assign {in_sign, in_exp, in_mant} = in_data[i*IN_W +: IN_W];
    assign exp_ones = &in_exp;
    assign exp_zero = ~|in_exp;
    assign mant_nz  = |in_mant;

    if (OUT_MANT >= IN_MANT) begin : g_widen
      assign kept   = OUT_MANT'(in_mant) << (OUT_MANT - IN_MANT);
      assign guard  = 1'b0;
      assign sticky = 1'b0;
    end else begin : g_narrow
      localparam int D = IN_MANT - OUT_MANT;
      assign kept  = in_mant[IN_MANT-1 -: OUT_MANT];
      assign guard = in_mant[D-1];
      if (D >= 2) begin : g_sticky
        assign sticky = |in_mant[D-2:0];
      end else begin : g_no_sticky
        assign sticky = 1'b0;
      end
    end

    // Stage 1: classified lane with rebiased exponent and rounding bits
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_sign   <= 1'b0;
        s1_nan    <= 1'b0;
        s1_snan   <= 1'b0;
        s1_inf    <= 1'b0;
        s1_zero   <= 1'b0;
        s1_znz    <= 1'b0;
        s1_e      <= '0;
        s1_mant   <= '0;
        s1_guard  <= 1'b0;
        s1_sticky <= 1'b0;
      end else if (s1_load) begin
        s1_sign   <= in_sign;
        s1_nan    <= exp_ones && mant_nz;
        s1_snan   <= exp_ones && mant_nz && !in_mant[IN_MANT-1];
        s1_inf    <= exp_ones && !mant_nz;
        s1_zero   <= exp_zero;
        s1_znz    <= exp_zero && mant_nz;
        s1_e      <= EW'(in_exp) + E_OFF;
        s1_mant   <= kept;
        s1_guard  <= guard;
        s1_sticky <= sticky;
      end
    end

    always_comb begin
      round_up = !s1_rmode && s1_guard && (s1_sticky || s1_mant[0]);
      sum      = {1'b0, s1_mant} + {{OUT_MANT{1'b0}}, round_up};
      e_rnd    = s1_e + EW'(sum[OUT_MANT]);
      res      = '0;
      lf       = '0;
      if (s1_nan) begin
        res   = {s1_sign, EXP_ONES, QNAN_MANT};
        lf[3] = s1_snan;
      end else if (s1_inf) begin
        res = {s1_sign, EXP_ONES, {OUT_MANT{1'b0}}};
      end else if (s1_zero) begin
        res     = {s1_sign, {(OUT_W-1){1'b0}}};
        lf[1:0] = {s1_znz, s1_znz};
      end else if ($signed(e_rnd) >= $signed(E_OVF)) begin
        // Only RNE without saturation may round up to infinity
        res     = (s1_sat || s1_rmode) ? {s1_sign, MAXF_EXP, {OUT_MANT{1'b1}}}
                                       : {s1_sign, EXP_ONES, {OUT_MANT{1'b0}}};
        lf[2]   = 1'b1;
        lf[0]   = 1'b1;
      end else if ($signed(e_rnd) < $signed(E_ONE)) begin
        res     = {s1_sign, {(OUT_W-1){1'b0}}};
        lf[1:0] = 2'b11;
      end else begin
        res   = {s1_sign, e_rnd[OUT_EXP-1:0], sum[OUT_MANT-1:0]};
        lf[0] = s1_guard || s1_sticky;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s2_res <= '0;
        s2_flg <= '0;
      end else if (s2_load) begin
        s2_res <= res;
        s2_flg <= lf;
      end
    end

    assign lane_res[i] = s2_res;
    assign lane_flg[i] = s2_flg;
  end

  always_comb begin
    out_data   = '0;
    beat_flags = '0;
    for (int i = 0; i < LANES; i++) begin
      out_data[i*OUT_W +: OUT_W] = lane_res[i];
      beat_flags                 = beat_flags | lane_flg[i];
    end
  end

  // A beat leaving in the same cycle as a clear still records its flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= '0;
    end else if (out_valid && out_ready) begin
      flags <= (flag_clear ? 4'b0 : flags) | beat_flags;
    end else if (flag_clear) begin
      flags <= '0;
    end
  end

endmodule

// File: tb/tb_fp_stream_converter.sv
// Bench for fp_stream_converter (FP32 -> FP16, 8 lanes): directed cases plus a randomized
// stream checked against a value-level conversion model and an in-order scoreboard.
module tb_fp_stream_converter;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         in_rmode;
  logic         in_sat;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   flags;
  logic         flag_clear;

  int           n_vec = 0;
  int           n_err = 0;
  logic [3:0]   model_flags;

  localparam int NRAND = 150;

  fp_stream_converter dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_rmode   (in_rmode),
    .in_sat     (in_sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .flags      (flags),
    .flag_clear (flag_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference conversion computed from the numeric value of the input
  function automatic void model_lane(input logic [31:0] x, input bit rtz, input bit sat,
                                     output logic [15:0] y, output logic [3:0] f);
    int          ex;
    int          e;
    int unsigned man;
    int unsigned q;
    int unsigned r;
    ex  = int'(x[30:23]);
    man = x[22:0];
    f   = 4'b0;
    if (ex == 255 && man != 0) begin
      y = {x[31], 15'h7E00};
      if (man < (1 << 22)) f = 4'b1000;
    end else if (ex == 255) begin
      y = {x[31], 15'h7C00};
    end else if (ex == 0) begin
      y = {x[31], 15'h0000};
      if (man != 0) f = 4'b0011;
    end else begin
      q = (man + (1 << 23)) / 8192;
      r = (man + (1 << 23)) % 8192;
      e = ex - 127 + 15;
      if (!rtz && (r > 4096 || (r == 4096 && (q % 2) == 1))) q++;
      if (q == 2048) begin
        q = 1024;
        e++;
      end
      if (r != 0) f[0] = 1'b1;
      if (e >= 31) begin
        f = 4'b0101;
        y = (sat || rtz) ? {x[31], 15'h7BFF} : {x[31], 15'h7C00};
      end else if (e <= 0) begin
        f = 4'b0011;
        y = {x[31], 15'h0000};
      end else begin
        y = {x[31], 5'(e), 10'(q - 1024)};
      end
    end
  endfunction

  function automatic void model_beat(input logic [255:0] d, input bit rtz, input bit sat,
                                     output logic [127:0] y, output logic [3:0] f);
    logic [15:0] ly;
    logic [3:0]  lf;
    y = '0;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      model_lane(d[i*32 +: 32], rtz, sat, ly, lf);
      y[i*16 +: 16] = ly;
      f = f | lf;
    end
  endfunction

  function automatic logic [31:0] rand_word();
    logic [7:0]  ex;
    logic [22:0] man;
    int          k;
    k   = $urandom_range(0, 9);
    man = 23'($urandom);
    case (k)
      0:       ex = 8'd0;
      1:       ex = 8'd255;
      2, 3:    ex = 8'($urandom_range(108, 114));
      4, 5:    ex = 8'($urandom_range(140, 144));
      default: ex = 8'($urandom_range(100, 150));
    endcase
    if ($urandom_range(0, 3) == 0) man[12:0] = 13'h1000;
    if (k <= 1 && $urandom_range(0, 1) == 0) man = '0;
    return {1'($urandom), ex, man};
  endfunction

  function automatic logic [255:0] rand_beat();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = rand_word();
    return d;
  endfunction

  function automatic logic [255:0] fill(input logic [31:0] lane0, input logic [31:0] rest);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = rest;
    d[31:0] = lane0;
    return d;
  endfunction

  // Single beat on an empty pipe with out_ready high: fixed two-cycle latency
  task automatic apply_stimulus(input string tag, input logic [255:0] d, input bit rm, input bit st,
                                input logic [15:0] lane0_exp, input logic [3:0] flags_exp,
                                input bit clr_at_out);
    logic [127:0] ey;
    logic [3:0]   ef;
    model_beat(d, rm, st, ey, ef);
    out_ready = 1'b1;
    in_data   = d;
    in_rmode  = rm;
    in_sat    = st;
    in_valid  = 1'b1;
    #1;
    check_output({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    check_output({tag, "_lat1"}, out_valid, 0);
    step();
    check_output({tag, "_lat2"}, out_valid, 1);
    check_output({tag, "_lane0"}, out_data[15:0], lane0_exp);
    check_output({tag, "_beat"}, out_data, ey);
    flag_clear = clr_at_out;
    step();
    flag_clear  = 1'b0;
    model_flags = clr_at_out ? ef : (model_flags | ef);
    check_output({tag, "_flags"}, flags, flags_exp);
    check_output({tag, "_flags_model"}, flags, model_flags);
  endtask

  task automatic clear_flags(input string tag);
    flag_clear = 1'b1;
    step();
    flag_clear  = 1'b0;
    model_flags = 4'b0;
    check_output({tag, "_cleared"}, flags, 0);
  endtask

  initial begin
    logic [127:0] qd[$];
    logic [3:0]   qf[$];
    logic [255:0] cur_d;
    bit           cur_rm;
    bit           cur_st;
    logic [127:0] ey;
    logic [3:0]   ef;
    logic [255:0] bp_d [4];
    logic [127:0] bp_y [4];
    logic [3:0]   bp_f [4];
    logic [127:0] held;
    int           sent;
    int           rcvd;
    int           acc;
    int           got;
    bit           in_tx;
    bit           out_tx;
    bit           accepted;

    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_rmode    = 1'b0;
    in_sat      = 1'b0;
    out_ready   = 1'b1;
    flag_clear  = 1'b0;
    model_flags = 4'b0;

    #22;
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_data", out_data, 0);
    check_output("rst_flags", flags, 0);
    reset = 1'b0;
    step();
    check_output("rst_in_ready", in_ready, 1);

    apply_stimulus("one", fill(32'h3F800000, 32'hBF800000), 1'b0, 1'b0, 16'h3C00, 4'h0, 1'b0);
    check_output("one_other_lanes", out_data[127:16], {7{16'hBC00}});

    // Randomized stream with random stalls on both sides
    sent   = 0;
    rcvd   = 0;
    cur_d  = rand_beat();
    cur_rm = 1'($urandom);
    cur_st = 1'($urandom);
    for (int c = 0; c < 4000 && rcvd < NRAND; c++) begin
      in_valid  = (sent < NRAND) && ($urandom_range(0, 3) != 0);
      in_data   = cur_d;
      in_rmode  = cur_rm;
      in_sat    = cur_st;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      in_tx  = in_valid && in_ready;
      out_tx = out_valid && out_ready;
      if (out_tx) begin
        if (qd.size() == 0) begin
          check_output("rnd_spurious_out", out_valid, 0);
        end else begin
          check_output("rnd_data", out_data, qd.pop_front());
          model_flags = model_flags | qf.pop_front();
          rcvd++;
        end
      end
      if (in_tx) begin
        model_beat(cur_d, cur_rm, cur_st, ey, ef);
        qd.push_back(ey);
        qf.push_back(ef);
        sent++;
        cur_d  = rand_beat();
        cur_rm = 1'($urandom);
        cur_st = 1'($urandom);
      end
      step();
      if (out_tx) check_output("rnd_flags", flags, model_flags);
    end
    in_valid = 1'b0;
    check_output("rnd_all_received", rcvd, NRAND);

    clear_flags("c0");
    apply_stimulus("tie_even", fill(32'h3F801000, 32'h3F801000), 1'b0, 1'b0, 16'h3C00, 4'h1, 1'b0);
    clear_flags("c1");
    apply_stimulus("rne_up", fill(32'h3F801001, 32'h3F801001), 1'b0, 1'b0, 16'h3C01, 4'h1, 1'b0);
    clear_flags("c2");
    apply_stimulus("rtz_trunc", fill(32'h3F801FFF, 32'h3F801FFF), 1'b1, 1'b0, 16'h3C00, 4'h1, 1'b0);
    clear_flags("c3");
    apply_stimulus("ovf_rne", fill(32'h477FF000, 32'h477FF000), 1'b0, 1'b0, 16'h7C00, 4'h5, 1'b0);
    clear_flags("c4");
    apply_stimulus("ovf_rtz", fill(32'h477FF000, 32'h477FF000), 1'b1, 1'b0, 16'h7BFF, 4'h1, 1'b0);
    clear_flags("c5");
    apply_stimulus("ovf_sat", fill(32'h477FF000, 32'h477FF000), 1'b0, 1'b1, 16'h7BFF, 4'h5, 1'b0);
    apply_stimulus("clr_set_wins", fill(32'h35800000, 32'h35800000), 1'b0, 1'b0, 16'h0000, 4'h3, 1'b1);
    clear_flags("c6");
    apply_stimulus("neg_inf", fill(32'hFF800000, 32'hFF800000), 1'b0, 1'b0, 16'hFC00, 4'h0, 1'b0);
    apply_stimulus("snan", fill(32'h7F800001, 32'h7F800001), 1'b0, 1'b0, 16'h7E00, 4'h8, 1'b0);
    clear_flags("c7");
    apply_stimulus("qnan", fill(32'h7FC00000, 32'h7FC00000), 1'b0, 1'b0, 16'h7E00, 4'h0, 1'b0);
    apply_stimulus("tiny", fill(32'h35800000, 32'h35800000), 1'b0, 1'b0, 16'h0000, 4'h3, 1'b0);
    clear_flags("c8");
    apply_stimulus("neg_sub", fill(32'h80000001, 32'h80000001), 1'b0, 1'b0, 16'h8000, 4'h3, 1'b0);
    clear_flags("c9");

    // Backpressure: only two beats fit while the consumer stalls
    for (int j = 0; j < 4; j++) begin
      bp_d[j] = rand_beat();
      model_beat(bp_d[j], 1'b0, 1'b0, bp_y[j], bp_f[j]);
    end
    out_ready = 1'b0;
    in_rmode  = 1'b0;
    in_sat    = 1'b0;
    acc       = 0;
    for (int c = 0; c < 4; c++) begin
      in_data  = bp_d[acc];
      in_valid = 1'b1;
      #1;
      accepted = in_ready;
      step();
      if (accepted) acc++;
    end
    in_valid = 1'b0;
    check_output("bp_accepted", acc, 2);
    check_output("bp_in_ready_low", in_ready, 0);
    check_output("bp_out_valid", out_valid, 1);
    check_output("bp_head", out_data, bp_y[0]);
    held = out_data;
    step();
    step();
    check_output("bp_hold_valid", out_valid, 1);
    check_output("bp_hold_data", out_data, held);
    out_ready = 1'b1;
    got       = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) begin
        if (got < 2) check_output("bp_drain", out_data, bp_y[got]);
        got++;
      end
      step();
    end
    check_output("bp_drain_count", got, 2);
    model_flags = bp_f[0] | bp_f[1];
    check_output("bp_flags", flags, model_flags);

    // Reset with two beats in flight and sticky flags set
    apply_stimulus("pre_rst_ovf", fill(32'h477FF000, 32'h477FF000), 1'b0, 1'b0, 16'h7C00,
                   model_flags | 4'h5, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = rand_beat();
    step();
    in_data = rand_beat();
    step();
    in_valid = 1'b0;
    check_output("inflight_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check_output("async_rst_valid", out_valid, 0);
    check_output("async_rst_flags", flags, 0);
    #3;
    reset       = 1'b0;
    model_flags = 4'b0;
    out_ready   = 1'b1;
    step();
    check_output("post_rst_in_ready", in_ready, 1);
    check_output("post_rst_no_out", out_valid, 0);
    apply_stimulus("post_rst_two", fill(32'h40000000, 32'h40000000), 1'b0, 1'b0, 16'h4000, 4'h0, 1'b0);
    step();
    check_output("post_rst_idle", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
